// File: rtl/player_motion.sv
// Sprite motion controller: one frame tick is spread over several Clk cycles
// so every pixel step is checked against the live wall-collision flags.
module player_motion #(
  parameter int X_START     = 320,
  parameter int Y_START     = 240,
  parameter int STEP_X      = 2,
  parameter int JUMP_FRAMES = 16,
  parameter int X_MAX       = 623,
  parameter int Y_MAX       = 463
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       BlockUp,
  input  logic       BlockDown,
  input  logic       BlockLeft,
  input  logic       BlockRight,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic       Grounded,
  output logic       Jumping,
  output logic       Busy
);

  localparam int JW = $clog2(JUMP_FRAMES + 1);

  localparam logic [7:0]    KEY_LEFT  = 8'h04;
  localparam logic [7:0]    KEY_RIGHT = 8'h07;
  localparam logic [7:0]    KEY_JUMP  = 8'h1A;
  localparam logic [9:0]    X_LIM     = 10'(X_MAX);
  localparam logic [9:0]    Y_LIM     = 10'(Y_MAX);
  localparam logic [9:0]    X_RST     = 10'(X_START);
  localparam logic [9:0]    Y_RST     = 10'(Y_START);
  localparam logic [3:0]    STEP_LIM  = 4'(STEP_X);
  localparam logic [JW-1:0] JUMP_LD   = JW'(JUMP_FRAMES);
  localparam logic [JW-1:0] JUMP_ONE  = JW'(1);

  typedef enum logic [1:0] {
    WAIT,
    HMOVE,
    VMOVE
  } state_t;

  state_t        state, state_nx;
  logic          frame_q, frame_q2;
  logic          tick;
  logic [7:0]    key_q, key_nx;
  logic [3:0]    step_cnt, step_nx;
  logic [JW-1:0] jump_cnt, jump_nx;
  logic [9:0]    x_nx, y_nx;
  logic          grounded_nx;
  logic          go_left, go_right;

  assign tick     = frame_q & ~frame_q2;
  assign go_left  = (key_q == KEY_LEFT) && !BlockLeft && (BallX != 10'd0);
  assign go_right = (key_q == KEY_RIGHT) && !BlockRight && (BallX < X_LIM);
  assign Busy     = (state != WAIT);
  assign Jumping  = (jump_cnt != '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= WAIT;
      frame_q  <= 1'b0;
      frame_q2 <= 1'b0;
      key_q    <= 8'h00;
      step_cnt <= 4'd0;
      jump_cnt <= '0;
      BallX    <= X_RST;
      BallY    <= Y_RST;
      Grounded <= 1'b0;
    end else begin
      state    <= state_nx;
      frame_q  <= frame_clk;
      frame_q2 <= frame_q;
      key_q    <= key_nx;
      step_cnt <= step_nx;
      jump_cnt <= jump_nx;
      BallX    <= x_nx;
      BallY    <= y_nx;
      Grounded <= grounded_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    key_nx      = key_q;
    step_nx     = step_cnt;
    jump_nx     = jump_cnt;
    x_nx        = BallX;
    y_nx        = BallY;
    grounded_nx = Grounded;
    unique case (state)
      WAIT: begin
        if (tick) begin
          key_nx   = keycode;
          step_nx  = 4'd0;
          state_nx = HMOVE;
        end
      end
      HMOVE: begin
        if (go_left || go_right) begin
          x_nx    = go_left ? BallX - 10'd1 : BallX + 10'd1;
          step_nx = step_cnt + 4'd1;
          if (step_nx == STEP_LIM) state_nx = VMOVE;
        end else begin
          state_nx = VMOVE;
        end
      end
      VMOVE: begin
        state_nx = WAIT;
        if (jump_cnt != '0) begin
          if (!BlockUp && BallY != 10'd0) begin
            y_nx    = BallY - 10'd1;
            jump_nx = jump_cnt - JUMP_ONE;
          end else begin
            jump_nx = '0;
          end
        end else if (!BlockDown && BallY < Y_LIM) begin
          y_nx        = BallY + 10'd1;
          grounded_nx = 1'b0;
        end else begin
          grounded_nx = 1'b1;
          if (key_q == KEY_JUMP) jump_nx = JUMP_LD;
        end
      end
      default: state_nx = WAIT;
    endcase
  end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: a frame-vector table plus
// hand-written sequences for timing, bounds, jumps and reset.
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       BlockUp, BlockDown, BlockLeft, BlockRight;
  logic [9:0] BallX, BallY;
  logic       Grounded, Jumping, Busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  player_motion dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .BlockUp    (BlockUp),
    .BlockDown  (BlockDown),
    .BlockLeft  (BlockLeft),
    .BlockRight (BlockRight),
    .BallX      (BallX),
    .BallY      (BallY),
    .Grounded   (Grounded),
    .Jumping    (Jumping),
    .Busy       (Busy)
  );

  // blk = {BlockUp, BlockDown, BlockLeft, BlockRight}
  typedef struct {
    logic [7:0] key;
    logic [3:0] blk;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       eg;
    logic       ej;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic set_blk(input logic [3:0] b);
    {BlockUp, BlockDown, BlockLeft, BlockRight} = b;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    set_blk(4'b0000);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: Busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic frame(input logic [7:0] k);
    keycode   = k;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    wait_idle();
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_pos(input string name, input logic [9:0] ex,
                           input logic [9:0] ey, input logic eg,
                           input logic ej);
    check(name, {10'd0, BallX, BallY, Grounded, Jumping},
          {10'd0, ex, ey, eg, ej});
  endtask

  initial begin
    int busy_n;

    vecs[0]  = '{8'h07, 4'b0000, 10'd322, 10'd241, 1'b0, 1'b0};
    vecs[1]  = '{8'h04, 4'b0000, 10'd320, 10'd242, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 4'b0100, 10'd320, 10'd242, 1'b1, 1'b0};
    vecs[3]  = '{8'h07, 4'b0101, 10'd320, 10'd242, 1'b1, 1'b0};
    vecs[4]  = '{8'h04, 4'b0100, 10'd318, 10'd242, 1'b1, 1'b0};
    vecs[5]  = '{8'h1A, 4'b0100, 10'd318, 10'd242, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 4'b0000, 10'd318, 10'd241, 1'b1, 1'b1};
    vecs[7]  = '{8'h07, 4'b1000, 10'd320, 10'd241, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 4'b0000, 10'd320, 10'd242, 1'b0, 1'b0};
    vecs[9]  = '{8'h1A, 4'b0000, 10'd320, 10'd243, 1'b0, 1'b0};
    vecs[10] = '{8'h04, 4'b0010, 10'd320, 10'd244, 1'b0, 1'b0};

    // reset state
    do_reset();
    check_pos("reset_pos", 10'd320, 10'd240, 1'b0, 1'b0);
    check("reset_busy", {31'd0, Busy}, 32'd0);

    // frame table
    for (int i = 0; i < 11; i++) begin
      set_blk(vecs[i].blk);
      frame(vecs[i].key);
      check_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                vecs[i].eg, vecs[i].ej);
    end
    set_blk(4'b0000);

    // right move timing; key change after latch is ignored
    do_reset();
    keycode   = 8'h07;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    keycode   = 8'h04;
    busy_n    = 0;
    for (int i = 0; i < 10; i++) begin
      if (Busy) busy_n++;
      if (i == 1) check("a_x_step1", {22'd0, BallX}, 32'd321);
      @(negedge Clk);
    end
    check("a_busy_cycles", busy_n, 3);
    check_pos("a_final", 10'd322, 10'd241, 1'b0, 1'b0);

    // BlockRight raised after the first step
    do_reset();
    keycode   = 8'h07;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    check("b_x_step1", {22'd0, BallX}, 32'd321);
    BlockRight = 1'b1;
    @(negedge Clk);
    check("b_vmove", {21'd0, BallX, Busy}, {21'd0, 10'd321, 1'b1});
    @(negedge Clk);
    check("b_done", {11'd0, BallX, BallY, Busy},
          {11'd0, 10'd321, 10'd241, 1'b0});
    BlockRight = 1'b0;

    // full jump from a wall
    do_reset();
    set_blk(4'b0100);
    frame(8'h1A);
    check_pos("c_launch", 10'd320, 10'd240, 1'b1, 1'b1);
    set_blk(4'b0000);
    for (int i = 0; i < 15; i++) frame(8'h1A);
    check_pos("c_rise15", 10'd320, 10'd225, 1'b1, 1'b1);
    frame(8'h1A);
    check_pos("c_rise16", 10'd320, 10'd224, 1'b1, 1'b0);
    frame(8'h00);
    check_pos("c_fall", 10'd320, 10'd225, 1'b0, 1'b0);

    // screen bounds
    do_reset();
    set_blk(4'b0100);
    for (int i = 0; i < 165; i++) frame(8'h04);
    check_pos("d_left_edge", 10'd0, 10'd240, 1'b1, 1'b0);
    for (int i = 0; i < 315; i++) frame(8'h07);
    check_pos("d_right_edge", 10'd623, 10'd240, 1'b1, 1'b0);
    set_blk(4'b0000);
    for (int i = 0; i < 230; i++) frame(8'h00);
    check_pos("d_floor", 10'd623, 10'd463, 1'b1, 1'b0);
    frame(8'h1A);
    check_pos("d_jump_floor", 10'd623, 10'd463, 1'b1, 1'b1);

    // tick during a busy frame is dropped
    do_reset();
    keycode   = 8'h07;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    check_pos("e_discard", 10'd322, 10'd241, 1'b0, 1'b0);

    // reset mid-HMOVE, then a normal frame
    do_reset();
    keycode   = 8'h07;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    check("f_pre_reset", {22'd0, BallX}, 32'd321);
    #2 Reset = 1'b1;
    #1;
    check("f_async", {11'd0, BallX, BallY, Busy},
          {11'd0, 10'd320, 10'd240, 1'b0});
    @(negedge Clk);
    check_pos("f_hold", 10'd320, 10'd240, 1'b0, 1'b0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    frame(8'h07);
    check_pos("f_after", 10'd322, 10'd241, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
